// File: rtl/lcd_img_pkg.sv
// rtl/lcd_img_pkg.sv - shared commands, states and default geometry for the LCD image processor
package lcd_img_pkg;

    // Default geometry; the top-level parameters override these per instance.
    localparam int DEF_IMG_LOG2 = 3;
    localparam int DEF_PIX_W    = 8;
    localparam int N            = 1 << DEF_IMG_LOG2;
    localparam int AW           = 2 * DEF_IMG_LOG2;
    localparam int PIX_MAX      = (1 << DEF_PIX_W) - 1;

    typedef enum logic [3:0] {
        CMD_WRITE    = 4'h0,
        CMD_UP       = 4'h1,
        CMD_DOWN     = 4'h2,
        CMD_LEFT     = 4'h3,
        CMD_RIGHT    = 4'h4,
        CMD_MAX      = 4'h5,
        CMD_MIN      = 4'h6,
        CMD_AVG      = 4'h7,
        CMD_ROT_CCW  = 4'h8,
        CMD_ROT_CW   = 4'h9,
        CMD_MIRROR_X = 4'hA,
        CMD_MIRROR_Y = 4'hB,
        CMD_ORIGIN   = 4'hC,
        CMD_INVERT   = 4'hD
    } cmd_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_EXEC,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational 2x2 window operator producing the four replacement pixels
module lcd_win_alu
    import lcd_img_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic [3:0]       cmd,
    input  logic [PIX_W-1:0] tl,
    input  logic [PIX_W-1:0] tr,
    input  logic [PIX_W-1:0] bl,
    input  logic [PIX_W-1:0] br,
    output logic [PIX_W-1:0] new_tl,
    output logic [PIX_W-1:0] new_tr,
    output logic [PIX_W-1:0] new_bl,
    output logic [PIX_W-1:0] new_br
);

    logic [PIX_W-1:0] max_top, max_bot, max_all;
    logic [PIX_W-1:0] min_top, min_bot, min_all;
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] avg;

    assign max_top = (tl > tr) ? tl : tr;
    assign max_bot = (bl > br) ? bl : br;
    assign max_all = (max_top > max_bot) ? max_top : max_bot;
    assign min_top = (tl < tr) ? tl : tr;
    assign min_bot = (bl < br) ? bl : br;
    assign min_all = (min_top < min_bot) ? min_top : min_bot;
    // Two extra bits hold the sum of four pixels without overflow.
    assign sum     = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    assign avg     = sum[PIX_W+1:2];

    // Select the replacement window; commands that do not touch pixels pass them through.
    always_comb begin
        new_tl = tl;
        new_tr = tr;
        new_bl = bl;
        new_br = br;
        case (cmd)
            CMD_MAX: begin
                new_tl = max_all; new_tr = max_all; new_bl = max_all; new_br = max_all;
            end
            CMD_MIN: begin
                new_tl = min_all; new_tr = min_all; new_bl = min_all; new_br = min_all;
            end
            CMD_AVG: begin
                new_tl = avg; new_tr = avg; new_bl = avg; new_br = avg;
            end
            CMD_ROT_CCW: begin
                new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
            end
            CMD_ROT_CW: begin
                new_tl = bl; new_tr = tl; new_br = tr; new_bl = br;
            end
            CMD_MIRROR_X: begin
                new_tl = bl; new_bl = tl; new_tr = br; new_br = tr;
            end
            CMD_MIRROR_Y: begin
                new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
            end
            CMD_INVERT: begin
                new_tl = ~tl; new_tr = ~tr; new_bl = ~bl; new_br = ~br;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_img_proc.sv
// rtl/lcd_img_proc.sv - image loader, 2x2 window command engine and write-out controller
module lcd_img_proc
    import lcd_img_pkg::*;
#(
    parameter int IMG_LOG2 = DEF_IMG_LOG2,
    parameter int PIX_W    = DEF_PIX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            cmd,
    input  logic                  cmd_valid,
    input  logic [PIX_W-1:0]      IROM_Q,
    output logic                  IROM_rd,
    output logic [2*IMG_LOG2-1:0] IROM_A,
    output logic                  IRAM_valid,
    output logic [PIX_W-1:0]      IRAM_D,
    output logic [2*IMG_LOG2-1:0] IRAM_A,
    output logic                  busy,
    output logic                  done
);

    localparam int                    SIDE   = 1 << IMG_LOG2;
    localparam int                    ADDR_W = 2 * IMG_LOG2;
    localparam int                    NPIX   = 1 << ADDR_W;
    localparam logic [IMG_LOG2-1:0]   ORG    = IMG_LOG2'(SIDE / 2);
    localparam logic [IMG_LOG2-1:0]   PMIN   = IMG_LOG2'(1);
    localparam logic [IMG_LOG2-1:0]   PMAX   = IMG_LOG2'(SIDE - 1);
    localparam logic [ADDR_W-1:0]     LAST   = ADDR_W'(NPIX - 1);

    state_e              state_q, state_d;
    logic                accept;
    logic [3:0]          cmd_q;
    logic [IMG_LOG2-1:0] px, py, xm1, ym1;
    logic [ADDR_W:0]     issue_cnt;
    logic                rd_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   a_tl, a_tr, a_bl, a_br;
    logic [PIX_W-1:0]    new_tl, new_tr, new_bl, new_br;
    logic [PIX_W-1:0]    pix_buf [NPIX];

    assign accept = (state_q == ST_IDLE) && cmd_valid && !busy;

    // Row-major addressing with a power-of-two side is just {y, x}.
    assign xm1  = px - 1'b1;
    assign ym1  = py - 1'b1;
    assign a_tl = {ym1, xm1};
    assign a_tr = {ym1, px};
    assign a_bl = {py, xm1};
    assign a_br = {py, px};

    lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
        .cmd    (cmd_q),
        .tl     (pix_buf[a_tl]),
        .tr     (pix_buf[a_tr]),
        .bl     (pix_buf[a_bl]),
        .br     (pix_buf[a_br]),
        .new_tl (new_tl),
        .new_tr (new_tr),
        .new_bl (new_bl),
        .new_br (new_br)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // Next-state logic: load ends on the final capture, write ends after the last address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (rd_d && addr_d == LAST) state_d = ST_IDLE;
            ST_IDLE:  if (accept) state_d = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
            ST_EXEC:  state_d = ST_IDLE;
            ST_WRITE: if (IRAM_A == LAST) state_d = ST_IDLE;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Registered outputs, ROM read sequencing, command latch and operation point.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b1;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            done       <= 1'b0;
            issue_cnt  <= '0;
            rd_d       <= 1'b0;
            addr_d     <= '0;
            cmd_q      <= '0;
            px         <= ORG;
            py         <= ORG;
        end else begin
            done   <= 1'b0;
            // One-cycle ROM latency: remember which address the data on IROM_Q belongs to.
            rd_d   <= IROM_rd;
            addr_d <= IROM_A;
            case (state_q)
                ST_LOAD: begin
                    if (!issue_cnt[ADDR_W]) begin
                        IROM_rd   <= 1'b1;
                        IROM_A    <= issue_cnt[ADDR_W-1:0];
                        issue_cnt <= issue_cnt + 1'b1;
                    end else begin
                        IROM_rd <= 1'b0;
                    end
                    if (state_d == ST_IDLE) busy <= 1'b0;
                end
                ST_IDLE: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        cmd_q <= cmd;
                        if (cmd == CMD_WRITE) begin
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= pix_buf[ADDR_W'(0)];
                        end
                    end
                end
                ST_EXEC: begin
                    busy <= 1'b0;
                    case (cmd_q)
                        CMD_UP:     if (py != PMIN) py <= py - 1'b1;
                        CMD_DOWN:   if (py != PMAX) py <= py + 1'b1;
                        CMD_LEFT:   if (px != PMIN) px <= px - 1'b1;
                        CMD_RIGHT:  if (px != PMAX) px <= px + 1'b1;
                        CMD_ORIGIN: begin
                            px <= ORG;
                            py <= ORG;
                        end
                        default: ;
                    endcase
                end
                ST_WRITE: begin
                    if (IRAM_A == LAST) begin
                        IRAM_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        IRAM_A <= IRAM_A + 1'b1;
                        IRAM_D <= pix_buf[IRAM_A + 1'b1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel buffer: filled from ROM during load, window rewritten as a unit in EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_LOAD && rd_d) begin
                pix_buf[addr_d] <= IROM_Q;
            end else if (state_q == ST_EXEC) begin
                pix_buf[a_tl] <= new_tl;
                pix_buf[a_tr] <= new_tr;
                pix_buf[a_bl] <= new_bl;
                pix_buf[a_br] <= new_br;
            end
        end
    end

endmodule

// File: tb/tb_lcd_img_proc.sv
// tb/tb_lcd_img_proc.sv - randomized and directed bench for lcd_img_proc against an image-level model
module tb_lcd_img_proc;

    localparam int NS = 8;
    localparam int NP = NS * NS;

    logic       clk = 1'b0;
    logic       reset, cmd_valid, IROM_rd, IRAM_valid, busy, done;
    logic [3:0] cmd;
    logic [7:0] IROM_Q, IRAM_D;
    logic [5:0] IROM_A, IRAM_A;

    logic       reset2, cmd_valid2, IROM_rd2, IRAM_valid2, busy2, done2;
    logic [3:0] cmd2, IROM_A2, IRAM_A2;
    logic [9:0] IROM_Q2, IRAM_D2;

    int rom [NP];
    int img [NP];
    int mx, my;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_img_proc #(.IMG_LOG2(3), .PIX_W(8)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
        .busy(busy), .done(done)
    );

    lcd_img_proc #(.IMG_LOG2(2), .PIX_W(10)) dut2 (
        .clk(clk), .reset(reset2), .cmd(cmd2), .cmd_valid(cmd_valid2),
        .IROM_Q(IROM_Q2), .IROM_rd(IROM_rd2), .IROM_A(IROM_A2),
        .IRAM_valid(IRAM_valid2), .IRAM_D(IRAM_D2), .IRAM_A(IRAM_A2),
        .busy(busy2), .done(done2)
    );

    // ROM models with one cycle of read latency.
    always @(posedge clk) IROM_Q  <= 8'(rom[IROM_A]);
    always @(posedge clk) IROM_Q2 <= 10'd1023;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Image-level reference: read the 2x2 window, compute, write it back.
    task automatic model_cmd(input int c);
        int a[4];
        int t[4];
        int o[4];
        int s, m, n;
        a[0] = (my - 1) * NS + mx - 1;
        a[1] = (my - 1) * NS + mx;
        a[2] = my * NS + mx - 1;
        a[3] = my * NS + mx;
        for (int i = 0; i < 4; i++) t[i] = img[a[i]];
        o = t;
        s = t[0] + t[1] + t[2] + t[3];
        m = t[0];
        n = t[0];
        for (int i = 1; i < 4; i++) begin
            if (t[i] > m) m = t[i];
            if (t[i] < n) n = t[i];
        end
        case (c)
            1:  my = (my > 1) ? my - 1 : 1;
            2:  my = (my < NS - 1) ? my + 1 : NS - 1;
            3:  mx = (mx > 1) ? mx - 1 : 1;
            4:  mx = (mx < NS - 1) ? mx + 1 : NS - 1;
            5:  o = '{m, m, m, m};
            6:  o = '{n, n, n, n};
            7:  o = '{s / 4, s / 4, s / 4, s / 4};
            8:  o = '{t[1], t[3], t[0], t[2]};
            9:  o = '{t[2], t[0], t[3], t[1]};
            10: o = '{t[2], t[3], t[0], t[1]};
            11: o = '{t[1], t[0], t[3], t[2]};
            12: begin mx = NS / 2; my = NS / 2; end
            13: o = '{255 - t[0], 255 - t[1], 255 - t[2], 255 - t[3]};
            default: ;
        endcase
        for (int i = 0; i < 4; i++) img[a[i]] = o[i];
    endtask

    // Called at a negedge; asserts reset, checks reset outputs and the full ROM sweep.
    task automatic reset_load(input bit hold_cmd);
        reset     = 1'b1;
        cmd       = 4'd5;
        cmd_valid = hold_cmd;
        @(negedge clk);
        check("reset_outputs", {busy, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, done}, {1'b1, 23'b0});
        reset = 1'b0;
        for (int c = 1; c <= NP; c++) begin
            @(negedge clk);
            check("load_rd_addr", {IROM_rd, IROM_A, busy}, {1'b1, 6'(c - 1), 1'b1});
        end
        @(negedge clk);
        check("load_rd_drop", {IROM_rd, busy}, 2'b01);
        @(negedge clk);
        check("load_busy_fall", busy, 1'b0);
        cmd_valid = 1'b0;
        img = rom;
        mx  = NS / 2;
        my  = NS / 2;
    endtask

    task automatic write_check();
        for (int i = 0; i < NP; i++) begin
            check("write_beat", {IRAM_valid, IRAM_A, IRAM_D}, {1'b1, 6'(i), 8'(img[i])});
            @(negedge clk);
        end
        check("write_end", {IRAM_valid, busy, done}, 3'b001);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
    endtask

    // Called at a negedge with the DUT idle; poke raises cmd_valid during the busy cycle.
    task automatic send_cmd(input int c, input bit poke);
        cmd       = 4'(c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
        if (c != 0) begin
            if (poke) begin
                cmd       = (c == 13) ? 4'd5 : 4'd13;
                cmd_valid = 1'b1;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            check("exec_busy_fall", busy, 1'b0);
            model_cmd(c);
        end else begin
            write_check();
        end
    endtask

    initial begin
        int c;
        reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
        reset2 = 1'b1; cmd2 = 4'd0; cmd_valid2 = 1'b0;
        for (int k = 0; k < NP; k++) rom[k] = k;
        @(negedge clk);

        // Identity image straight out, then max at the origin window.
        reset_load(1'b0);
        send_cmd(0, 1'b0);
        send_cmd(5, 1'b0);
        send_cmd(0, 1'b0);

        // Average on a fresh image.
        reset_load(1'b0);
        send_cmd(7, 1'b0);
        send_cmd(0, 1'b0);

        // Left shift saturates at x=1, then clockwise rotate there.
        for (int i = 0; i < 5; i++) send_cmd(3, 1'b0);
        send_cmd(9, 1'b0);
        send_cmd(0, 1'b0);

        // Origin reset after moving, confirmed by a max at the origin window.
        send_cmd(4, 1'b0);
        send_cmd(1, 1'b0);
        send_cmd(12, 1'b0);
        send_cmd(5, 1'b0);
        send_cmd(0, 1'b0);

        // cmd_valid held through load; invert of 0x0F; cmd_valid raised during EXEC.
        rom[27] = 8'h0F;
        reset_load(1'b1);
        send_cmd(0, 1'b0);
        send_cmd(13, 1'b0);
        send_cmd(6, 1'b1);
        send_cmd(0, 1'b0);

        // Randomized image and command stream.
        for (int k = 0; k < NP; k++) rom[k] = int'($urandom_range(0, 255));
        reset_load(1'b0);
        for (int j = 0; j < 64; j++) begin
            c = (j % 8 == 7) ? 0 : int'($urandom_range(1, 15));
            send_cmd(c, $urandom_range(0, 3) == 0);
        end

        // Reset during write-out at beat 20 restarts the load from address 0.
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("abort_write_beat", {IRAM_valid, IRAM_A, IRAM_D}, {1'b1, 6'(i), 8'(img[i])});
            if (i < 19) @(negedge clk);
        end
        for (int k = 0; k < NP; k++) rom[k] = int'($urandom_range(0, 255));
        reset_load(1'b0);
        send_cmd(0, 1'b0);

        // 4x4, 10-bit instance: 16-beat load/write, average of saturated pixels.
        reset2 = 1'b1;
        @(negedge clk);
        check("small_reset", {busy2, IROM_rd2, IROM_A2, IRAM_valid2, done2}, {1'b1, 7'b0});
        reset2 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("small_load", {IROM_rd2, IROM_A2}, {1'b1, 4'(i - 1)});
        end
        @(negedge clk);
        check("small_load_end", {IROM_rd2, busy2}, 2'b01);
        @(negedge clk);
        check("small_busy_fall", busy2, 1'b0);
        cmd2 = 4'd7;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        @(negedge clk);
        check("small_exec_done", busy2, 1'b0);
        cmd2 = 4'd0;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("small_write", {IRAM_valid2, IRAM_A2, IRAM_D2}, {1'b1, 4'(i), 10'd1023});
            @(negedge clk);
        end
        check("small_write_end", {IRAM_valid2, busy2, done2}, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
